dff_pipe: RTL and testbench
===========================

# dff_pipe

Parametrised elastic register pipeline: successor to the single-bit D flip-flop, generalised to WIDTH-bit data and DEPTH stages, each stage carrying its own valid bit. A valid/ready handshake adds backpressure, bubble collapse, synchronous flush and an occupancy count. Used wherever a datapath needs a retimed, stallable delay line between a producer and a consumer.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 4, number of register stages (≥1; DEPTH=0 is a compile-time error)
- RST_VAL, '0, WIDTH-bit value loaded into every data register on reset
- clk  in  1  clock; all state changes on posedge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all stages
- in_valid  in  1  producer offers in_data
- in_ready  out  1  pipeline accepts in_data this cycle
- in_data  in  WIDTH  input word
- out_valid  out  1  last stage holds a valid word
- out_ready  in  1  consumer accepts out_data
- out_data  out  WIDTH  last-stage word
- count  out  $clog2(DEPTH+1)  number of valid stages

## Operation
- Per stage i (0 = input side, DEPTH-1 = output side): registers v[i], d[i].
- Stage ready: r[DEPTH-1] = !v[DEPTH-1] | out_ready; r[i] = !v[i] | r[i+1]. Combinational chain, no skid.
- in_ready = r[0] & !flush.
- Stage i loads when r[i]: v[i] <= upstream valid, d[i] <= upstream data only if upstream valid (d holds otherwise). Upstream of stage 0 is in_valid/in_data.
- Transfer on input side: in_valid & in_ready; on output side: out_valid & out_ready.
- Bubbles collapse: an empty stage accepts from upstream even when downstream is stalled.
- Words leave in arrival order; no word is duplicated or dropped except by flush/reset.
- flush: all v[i] <= 0 next edge; d[i] unchanged; input offered that cycle is not accepted (in_ready=0); out_valid still reflects current state, but an output transfer in the flush cycle is honoured as completed.
- count = popcount(v); updated registered, equals number of valid stages after each edge; range 0..DEPTH.
- rst low (async): all v[i]=0, all d[i]=RST_VAL, count=0, out_valid=0, out_data=RST_VAL, in_ready=1 (flush=0). Deassertion releases on the next posedge.

## Timing
- Latency: word accepted at edge N appears on out_data/out_valid after edge N+DEPTH-1 (visible in cycle N+DEPTH-1..), i.e. DEPTH cycles through an empty, unstalled pipe.
- Throughput: one word per cycle when out_ready held high.
- in_ready depends combinationally on out_ready (path length DEPTH); out_valid, out_data, count are registered outputs only.
- Full (count=DEPTH) with out_ready=0: in_ready=0, all stages hold.
- Full with out_ready=1: simultaneous accept and emit, count stays DEPTH.
- flush and out_ready in the same cycle: output word counts as consumed; pipe empty next cycle.
- Reset mid-stream: contents lost immediately, no output transfer occurs while rst low.

## Structure
- Package dff_pkg: function for count width (clog2(DEPTH+1)), and a typedef'd stage struct {logic valid; logic [WIDTH-1:0] data} if parametrised types are supported; otherwise keep vectors local.
- One sub-module: dff_stage (single valid/data register with load enable, flush, async active-low reset to RST_VAL); dff_pipe instantiates DEPTH of them in a generate loop plus the ready chain and count register.

## Test plan
- Reset: hold rst=0 with random inputs, WIDTH=8, RST_VAL=8'hA5 -> out_valid=0, out_data=8'hA5, count=0, in_ready=1.
- Streaming: DEPTH=4, out_ready=1, push 1,2,3… every cycle -> first word out 4 cycles after acceptance, then one word per cycle, order preserved, count steady at 4.
- Backpressure: out_ready=0, push 6 words -> exactly 4 accepted, in_ready=0 after 4th, count=4; release out_ready -> words 1..4 emerge in order, then 5,6.
- Bubble collapse: push word at cycle 0 and cycle 3 with out_ready=0 -> both packed into stages 3 and 2, count=2, no gap on output when released.
- Flush: pipe holding 3 words, assert flush one cycle with in_valid=1 -> in_ready=0 that cycle, count=0 next cycle, none of the 3 words nor the offered word ever emerges.
- Async reset mid-operation: full pipe, pull rst low between edges -> out_valid drops to 0 without a clock edge, count=0; after release, new stream passes with normal latency.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared helpers for the dff_pipe elastic register pipeline.
package dff_pkg;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Producer/consumer bundle for dff_pipe; master is the environment, slave is the pipe.
interface dff_pipe_if
  import dff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = cnt_w(DEPTH);

  // A word moves on a side only in a cycle where valid and ready are both high;
  // valid never waits for ready, and ready may depend combinationally on valid/out_ready.
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/dff_stage.sv
// One pipeline register: a valid bit plus a data word that only changes when valid data arrives.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush drops validity only; the stale word stays so the data path never toggles needlessly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= RST_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage register pipeline with per-stage valid, bubble collapse,
// synchronous flush and a registered occupancy count.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic        clk,
  input  logic        rst,
  dff_pipe_if.slave   bus
);

  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 1) begin : g_depth_check
    $error("dff_pipe: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] r;
  logic [WIDTH-1:0] d [DEPTH];
  logic             tail_full;
  logic             in_xfer;
  logic             out_xfer;
  logic [CW-1:0]    count_q;

  // Stage i may load when out_ready is high or any stage from i to the output is empty.
  always_comb begin
    tail_full = 1'b1;
    r         = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & v[i];
      r[i]      = ~tail_full | bus.out_ready;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
    end else begin : g_body
      assign up_valid = v[i-1];
      assign up_data  = d[i-1];
    end

    dff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.flush),
      .load     (r[i]),
      .up_valid (up_valid),
      .up_data  (up_data),
      .valid    (v[i]),
      .data     (d[i])
    );
  end

  assign bus.in_ready  = r[0] & ~bus.flush;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = v[DEPTH-1] & bus.out_ready;

  // Tracks popcount(v): words are never duplicated or lost outside flush/reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (bus.flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  assign bus.count = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: vector table, directed corner sequences and
// randomized traffic against a word/position queue model.
module tb_dff_pipe;

  localparam int               WIDTH   = 8;
  localparam int               DEPTH   = 4;
  localparam logic [WIDTH-1:0] RST_VAL = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dff_pipe #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  bit chk_en = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Each word in flight has a position (0 = input stage). A word moves one stage
  // forward when out_ready is high or some slot ahead of it is free; with k words
  // ahead and DEPTH-1-p slots ahead, a free slot exists exactly when slots > k.
  logic [WIDTH-1:0] exp_q[$];
  int               pos_q[$];

  function automatic bit m_out_valid();
    return (exp_q.size() > 0) && (pos_q[0] == DEPTH - 1);
  endfunction

  function automatic bit m_in_ready();
    return !bus.flush && ((exp_q.size() < DEPTH) || bus.out_ready);
  endfunction

  always @(posedge clk or negedge rst) begin
    bit acc;
    bit emit;
    if (!rst) begin
      exp_q.delete();
      pos_q.delete();
    end else begin
      acc  = bus.in_valid && m_in_ready();
      emit = m_out_valid() && bus.out_ready;
      if (bus.flush) begin
        exp_q.delete();
        pos_q.delete();
      end else begin
        for (int k = 0; k < pos_q.size(); k++) begin
          if (pos_q[k] < DEPTH - 1 && (bus.out_ready || (DEPTH - 1 - pos_q[k]) > k))
            pos_q[k] = pos_q[k] + 1;
        end
        if (emit) begin
          void'(exp_q.pop_front());
          void'(pos_q.pop_front());
        end
        if (acc) begin
          exp_q.push_back(bus.in_data);
          pos_q.push_back(0);
        end
      end
    end
  end

  // Scoreboard: every cycle, compare DUT outputs to the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model.in_ready", bus.in_ready, m_in_ready());
      check("model.out_valid", bus.out_valid, m_out_valid());
      check("model.count", bus.count, exp_q.size());
      if (m_out_valid()) check("model.out_data", bus.out_data, exp_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(bit iv, logic [WIDTH-1:0] dat, bit ordy, bit fl);
    bus.in_valid  = iv;
    bus.in_data   = dat;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(string tag, bit eir, bit eov, logic [WIDTH-1:0] eod, int ecnt);
    @(negedge clk);
    check({tag, ".in_ready"}, bus.in_ready, eir);
    check({tag, ".out_valid"}, bus.out_valid, eov);
    check({tag, ".count"}, bus.count, ecnt);
    if (eov) check({tag, ".out_data"}, bus.out_data, eod);
    next_cycle();
  endtask

  task automatic reset_pipe();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit               iv;
    logic [WIDTH-1:0] dat;
    bit               ordy;
    bit               fl;
    bit               eir;
    bit               eov;
    logic [WIDTH-1:0] eod;
    int               ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit iv, logic [WIDTH-1:0] dat, bit ordy, bit fl,
                              bit eir, bit eov, logic [WIDTH-1:0] eod, int ecnt);
    vec_t x;
    x.iv = iv; x.dat = dat; x.ordy = ordy; x.fl = fl;
    x.eir = eir; x.eov = eov; x.eod = eod; x.ecnt = ecnt;
    return x;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    // Backpressure: offer 1..6 with the consumer stalled, then release it.
    tbl.push_back(mk(1, 8'd1, 0, 0, 1, 0, 8'd0, 0));
    tbl.push_back(mk(1, 8'd2, 0, 0, 1, 0, 8'd0, 1));
    tbl.push_back(mk(1, 8'd3, 0, 0, 1, 0, 8'd0, 2));
    tbl.push_back(mk(1, 8'd4, 0, 0, 1, 0, 8'd0, 3));
    tbl.push_back(mk(1, 8'd5, 0, 0, 0, 1, 8'd1, 4));
    tbl.push_back(mk(1, 8'd6, 0, 0, 0, 1, 8'd1, 4));
    tbl.push_back(mk(1, 8'd5, 1, 0, 1, 1, 8'd1, 4));
    tbl.push_back(mk(1, 8'd6, 1, 0, 1, 1, 8'd2, 4));
    tbl.push_back(mk(0, 8'd0, 1, 0, 1, 1, 8'd3, 4));
    tbl.push_back(mk(0, 8'd0, 1, 0, 1, 1, 8'd4, 3));
    tbl.push_back(mk(0, 8'd0, 1, 0, 1, 1, 8'd5, 2));
    tbl.push_back(mk(0, 8'd0, 1, 0, 1, 1, 8'd6, 1));
    tbl.push_back(mk(0, 8'd0, 1, 0, 1, 0, 8'd0, 0));

    chk_en = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Reset held with random traffic on the inputs.
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      @(negedge clk);
      check("reset.out_valid", bus.out_valid, 1'b0);
      check("reset.out_data", bus.out_data, RST_VAL);
      check("reset.count", bus.count, 0);
      check("reset.in_ready", bus.in_ready, 1'b1);
      next_cycle();
    end
    rst = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);

    // Streaming at full rate.
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, WIDTH'(c + 1), 1'b1, 1'b0);
      expect_out("stream", 1'b1, c >= DEPTH, WIDTH'(c + 1 - DEPTH), (c < DEPTH) ? c : DEPTH);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int c = 0; c < DEPTH; c++) next_cycle();
    reset_pipe();

    // Backpressure table.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].dat, tbl[i].ordy, tbl[i].fl);
      expect_out($sformatf("bp[%0d]", i), tbl[i].eir, tbl[i].eov, tbl[i].eod, tbl[i].ecnt);
    end

    // Bubble collapse: two words three cycles apart pack together while stalled.
    drive(1'b1, 8'h11, 1'b0, 1'b0); expect_out("bubble0", 1, 0, 8'h00, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0); expect_out("bubble1", 1, 0, 8'h00, 1);
    expect_out("bubble2", 1, 0, 8'h00, 1);
    drive(1'b1, 8'h22, 1'b0, 1'b0); expect_out("bubble3", 1, 0, 8'h00, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0); expect_out("bubble4", 1, 1, 8'h11, 2);
    expect_out("bubble5", 1, 1, 8'h11, 2);
    expect_out("bubble6", 1, 1, 8'h11, 2);
    drive(1'b0, 8'h00, 1'b1, 1'b0); expect_out("bubble7", 1, 1, 8'h11, 2);
    expect_out("bubble8", 1, 1, 8'h22, 1);
    expect_out("bubble9", 1, 0, 8'h00, 0);

    // Flush with three words inside and a word offered in the flush cycle.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, WIDTH'(8'h31 + c), 1'b0, 1'b0);
      expect_out("flush_fill", 1, 0, 8'h00, c);
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b1); expect_out("flush_cyc", 0, 0, 8'h00, 3);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) expect_out("flush_after", 1, 0, 8'h00, 0);

    // Flush in the same cycle as an output transfer.
    for (int c = 0; c < DEPTH; c++) begin
      drive(1'b1, WIDTH'(8'h41 + c), 1'b0, 1'b0);
      expect_out("flushout_fill", 1, 0, 8'h00, c);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b1); expect_out("flushout_cyc", 0, 1, 8'h41, 4);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) expect_out("flushout_after", 1, 0, 8'h00, 0);

    // Asynchronous reset of a full pipe between clock edges.
    for (int c = 0; c < DEPTH; c++) begin
      drive(1'b1, WIDTH'(8'h51 + c), 1'b0, 1'b0);
      expect_out("areset_fill", 1, 0, 8'h00, c);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0); expect_out("areset_full", 0, 1, 8'h51, 4);
    #3;
    rst = 1'b0;
    #1;
    check("areset.out_valid", bus.out_valid, 1'b0);
    check("areset.count", bus.count, 0);
    check("areset.out_data", bus.out_data, RST_VAL);
    check("areset.in_ready", bus.in_ready, 1'b1);
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 8'h5A, 1'b0, 1'b0); expect_out("relat0", 1, 0, 8'h00, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int c = 1; c < DEPTH; c++) expect_out("relat_wait", 1, 0, 8'h00, 1);
    expect_out("relat_out", 1, 1, 8'h5A, 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0); expect_out("relat_take", 1, 1, 8'h5A, 1);
    expect_out("relat_empty", 1, 0, 8'h00, 0);

    // Randomized traffic, consumer readiness biased per segment.
    for (int i = 0; i < 400; i++) begin
      int seg;
      seg = (i / 50) % 4;
      drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom),
            1'($urandom_range(0, 2) < seg), 1'($urandom_range(0, 39) == 0));
      next_cycle();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int c = 0; c < DEPTH + 2; c++) next_cycle();
    @(negedge clk);
    check("drain.count", bus.count, 0);
    check("drain.out_valid", bus.out_valid, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
